// File: rtl/data_read_rd_arbiter.sv
// Two-requester round-robin front end for one AXI4-Lite read channel.
// Allows one read in flight at a time; a watchdog converts a missing R beat into an error response.
module data_read_rd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic                     ptr_q, ptr_d;
  logic                     owner_q, owner_d;
  logic [ADDR_W-1:0]        araddr_q, araddr_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [1:0]               rsp_vld_q, rsp_vld_d;
  logic [1:0]               rsp_err_q, rsp_err_d;
  logic [1:0][DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]               req_v, gnt;
  logic                     sel;
  logic                     tmo_hit;
  logic                     rresp_unused;

  // Only RRESP[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign rresp_unused = M_AXI_RRESP[0];

  assign req_v   = {req1_valid, req0_valid};
  assign tmo_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    araddr_d   = araddr_q;
    timer_d    = timer_q;
    rsp_vld_d  = '0;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    gnt        = '0;
    sel        = 1'b0;
    case (state_q)
      IDLE: begin
        // Hold off one cycle while the response pulse is out, giving the 4-cycle issue cadence.
        if (rsp_vld_q == 2'b00 && req_v != 2'b00) begin
          sel      = (req_v == 2'b11) ? ptr_q : req_v[1];
          gnt[sel] = 1'b1;
          owner_d  = sel;
          araddr_d = sel ? req1_addr : req0_addr;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (M_AXI_ARREADY) begin
          timer_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (M_AXI_RVALID) begin
          rsp_vld_d[owner_q]  = 1'b1;
          rsp_data_d[owner_q] = M_AXI_RDATA;
          rsp_err_d[owner_q]  = M_AXI_RRESP[1];
          ptr_d               = ~owner_q;
          state_d             = IDLE;
        end else if (tmo_hit) begin
          rsp_vld_d[owner_q]  = 1'b1;
          rsp_data_d[owner_q] = '0;
          rsp_err_d[owner_q]  = 1'b1;
          ptr_d               = ~owner_q;
          state_d             = DRAIN;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      DRAIN: begin
        if (M_AXI_RVALID) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      araddr_q   <= '0;
      timer_q    <= '0;
      rsp_vld_q  <= '0;
      rsp_err_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      araddr_q   <= araddr_d;
      timer_q    <= timer_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Grant is combinational from IDLE; masked so nothing is accepted while reset is held.
  assign req0_ready    = gnt[0] & S_AXI_ARESETN;
  assign req1_ready    = gnt[1] & S_AXI_ARESETN;
  assign rsp0_valid    = rsp_vld_q[0];
  assign rsp1_valid    = rsp_vld_q[1];
  assign rsp0_data     = rsp_data_q[0];
  assign rsp1_data     = rsp_data_q[1];
  assign rsp0_err      = rsp_err_q[0];
  assign rsp1_err      = rsp_err_q[1];
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = (state_q == ADDR);
  assign M_AXI_RREADY  = (state_q == DATA) || (state_q == DRAIN);

endmodule

// File: tb/tb_data_read_rd_arbiter.sv
// Directed bench for data_read_rd_arbiter: scripted AXI slave, expected responses queued on grant
// and checked (requester, data, err, arrival cycle) by an independent monitor.
module tb_data_read_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_addr, req1_addr;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] ARADDR, RDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  RRESP;

  always #5 clk = ~clk;

  data_read_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, failed = 0;

  typedef struct {int port; logic [31:0] data; logic err; int cyc;} exp_t;
  exp_t sb[$];

  // slave configuration and state
  int          ar_stall = 0, r_delay = 0;
  logic [31:0] slv_base = 0;
  logic [1:0]  slv_resp = 2'b00;
  int          sstate = 0, scnt = 0, rcnt = 0;
  logic [31:0] s_addr, ar_addr_s;
  logic        ar_hs = 1'b0, r_hs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // handshake sampling away from the clock edge
  initial forever begin
    @(negedge clk);
    ar_hs     = ARVALID && ARREADY;
    ar_addr_s = ARADDR;
    r_hs      = RVALID && RREADY;
  end

  // scripted slave: ARREADY after ar_stall cycles, RVALID r_delay cycles after AR handshake
  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ARREADY = 1'b0; RVALID = 1'b0; sstate = 0; scnt = 0; rcnt = 0;
      end else begin
        if (sstate == 2) begin
          if (r_hs) begin RVALID = 1'b0; sstate = 0; scnt = 0; end
        end else if (sstate == 0) begin
          if (ar_hs) begin
            ARREADY = 1'b0; s_addr = ar_addr_s; rcnt = 0; sstate = 1;
          end else if (ARVALID) begin
            if (scnt < ar_stall) begin scnt++; ARREADY = 1'b0; end
            else ARREADY = 1'b1;
          end else begin
            ARREADY = 1'b0; scnt = 0;
          end
        end
        if (sstate == 1) begin
          if (rcnt == r_delay) begin
            RVALID = 1'b1; RDATA = slv_base ^ s_addr; RRESP = slv_resp; sstate = 2;
          end else rcnt++;
        end
      end
    end
  end

  task automatic check_rsp(input int p, input logic [31:0] d, input logic e);
    exp_t x;
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL rsp%0d_unexpected: got response data 0x%0h err %0b, want no response (cycle %0d)", p, d, e, cyc);
    end else begin
      x = sb.pop_front();
      chk("rsp_port", p, x.port);
      chk("rsp_data", d, x.data);
      chk("rsp_err", 32'(e), 32'(x.err));
      chk("rsp_cycle", cyc, x.cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rsp0_valid) check_rsp(0, rsp0_data, rsp0_err);
      if (rsp1_valid) check_rsp(1, rsp1_data, rsp1_err);
    end
  end

  task automatic drive_req(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin req0_valid = v; req0_addr = a; end
    else        begin req1_valid = v; req1_addr = a; end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] d, input logic e,
                       input int lat, input bit push);
    bit got = 0;
    @(posedge clk); #1;
    drive_req(p, 1'b1, a);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        got = 1;
        if (push) sb.push_back('{p, d, e, cyc + lat});
      end
    end
    chk("grant_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    drive_req(p, 1'b0, a);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int n, last, g;
    bit got, stable;
    req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_ctrl", 32'({ARVALID, RREADY, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp0_err, rsp1_err}), 0);
    chk("reset_araddr", ARADDR, 0);
    chk("reset_rsp0_data", rsp0_data, 0);
    @(posedge clk); #3 rst_n = 1'b1;

    // contention from reset: 0,1,0,1 at 4-cycle spacing
    slv_base = 32'h5A5A0000;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'h100); drive_req(1, 1'b1, 32'h200);
    n = 0; last = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        chk("contention_order", g, n % 2);
        if (n > 0) chk("contention_spacing", cyc - last, 4);
        last = cyc;
        sb.push_back('{g, (g == 1) ? 32'h5A5A0200 : 32'h5A5A0100, 1'b0, cyc + 3});
        n++;
      end
    end
    chk("contention_grants", n, 4);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 0); drive_req(1, 1'b0, 0);
    wait_drain(20);

    // single read, minimum latency
    slv_base = 32'hCAFE0011;
    issue(0, 32'h10, 32'hCAFE0001, 1'b0, 3, 1);
    wait_drain(20);
    chk("rsp0_data_hold", rsp0_data, 32'hCAFE0001);

    // slave error on req1, then pointer favours req0
    slv_base = 32'hDEAD0000; slv_resp = 2'b10;
    issue(1, 32'h24, 32'hDEAD0024, 1'b1, 3, 1);
    wait_drain(20);
    slv_resp = 2'b00; slv_base = 32'h11110000;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'h50); drive_req(1, 1'b1, 32'h60);
    got = 0; g = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = 1; g = req1_ready ? 1 : 0;
        sb.push_back('{g, (g == 1) ? 32'h11110060 : 32'h11110050, 1'b0, cyc + 3});
      end
    end
    chk("ptr_after_err", g, 0);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 0); drive_req(1, 1'b0, 0);
    wait_drain(20);
    chk("rsp1_data_hold", rsp1_data, 32'hDEAD0024);
    chk("rsp1_err_hold", 32'(rsp1_err), 1);

    // watchdog: 8 DATA cycles then err/0, late beat drained silently
    slv_base = 32'h0BAD0000; r_delay = 28;
    issue(0, 32'h30, 32'h0, 1'b1, 10, 1);
    wait_drain(40);
    chk("drain_rready", 32'(RREADY), 1);
    for (int i = 0; i < 60 && sstate != 0; i++) @(negedge clk);
    chk("late_beat_consumed", sstate, 0);
    r_delay = 0;
    issue(0, 32'h34, 32'h0BAD0034, 1'b0, 3, 1);
    wait_drain(20);

    // AR stall of 50 cycles: address phase held, no timeout
    slv_base = 32'h12340000; ar_stall = 50;
    issue(0, 32'h40, 32'h12340040, 1'b0, 53, 1);
    stable = 1;
    repeat (50) begin
      @(negedge clk);
      if (!(ARVALID && ARADDR == 32'h40 && !RREADY)) stable = 0;
    end
    chk("ar_stall_stable", 32'(stable), 1);
    wait_drain(40);
    ar_stall = 0;

    // async reset in DATA: aborted, then req1 alone granted
    slv_base = 32'h77770000; r_delay = 10;
    issue(0, 32'h70, 32'h0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    drive_req(1, 1'b1, 32'h88);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({ARVALID, RREADY, rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 0);
    chk("rst_async_rsp0_data", rsp0_data, 0);
    chk("rst_async_araddr", ARADDR, 0);
    r_delay = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req1_ready) begin
        got = 1;
        sb.push_back('{1, 32'h77770088, 1'b0, cyc + 3});
      end
    end
    chk("post_reset_grant1", 32'(got), 1);
    @(posedge clk); #1;
    drive_req(1, 1'b0, 0);
    wait_drain(20);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
